alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 79 +++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: 4-entry FIFO of ALU results with head flags and saturating drop counter.
// Define ALU_RESULT_PARITY_EN to store per-entry even parity and drive Res_Parity.
module alu_result_fifo (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Mux_Out,
    input  logic [3:0] Opcode,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic [7:0] Res_Data,
    output logic [3:0] Res_Opcode,
    output logic       Res_Zero,
    output logic       Res_Neg,
    output logic       Res_Valid,
    input  logic       Res_Ready,
    output logic [2:0] Count,
    output logic [7:0] Drop_Count
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic       Res_Parity
`endif
);
    logic [7:0] data_q [4];
    logic [3:0] op_q [4];
    logic [3:0] zero_q, neg_q;
    logic [1:0] wr_ptr, rd_ptr;
    logic       push, pop;
`ifdef ALU_RESULT_PARITY_EN
    logic [3:0] par_q;
`endif

    // In_Ready looks only at Count, so a pop never frees a slot for the same edge
    assign In_Ready  = Count != 3'd4;
    assign Res_Valid = Count != 3'd0;
    assign push      = In_Valid && In_Ready;
    assign pop       = Res_Valid && Res_Ready;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                op_q[i]   <= '0;
            end
            zero_q     <= '0;
            neg_q      <= '0;
`ifdef ALU_RESULT_PARITY_EN
            par_q      <= '0;
`endif
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Count      <= '0;
            Drop_Count <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= Mux_Out;
                op_q[wr_ptr]   <= Opcode;
                zero_q[wr_ptr] <= Mux_Out == 8'h00;
                neg_q[wr_ptr]  <= Mux_Out[7];
`ifdef ALU_RESULT_PARITY_EN
                par_q[wr_ptr]  <= ^Mux_Out;
`endif
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            Count <= Count + {2'b00, push} - {2'b00, pop};
            if (In_Valid && !In_Ready && Drop_Count != 8'hFF)
                Drop_Count <= Drop_Count + 8'd1;
        end
    end

    assign Res_Data   = Res_Valid ? data_q[rd_ptr] : 8'h00;
    assign Res_Opcode = Res_Valid ? op_q[rd_ptr] : 4'h0;
    assign Res_Zero   = Res_Valid && zero_q[rd_ptr];
    assign Res_Neg    = Res_Valid && neg_q[rd_ptr];
`ifdef ALU_RESULT_PARITY_EN
    assign Res_Parity = Res_Valid && par_q[rd_ptr];
`endif
endmodule
